// File: rtl/tcb_arb_rr_pkg.sv
// Shared constants, response-pipe slot type and index helper for the TCB round-robin arbiter.
package tcb_arb_rr_pkg;

  localparam int unsigned TCB_AW  = 32;
  localparam int unsigned TCB_DW  = 32;
  // Read response delay of tcb_mem_1p; arbiter instances in front of it must match.
  localparam int unsigned TCB_DLY = 1;
  // Widest manager index supported (PN up to 8).
  localparam int unsigned IDX_W   = 3;

  // One response-pipe stage: transfer taken, and which manager issued it.
  typedef struct packed {
    logic             vld;
    logic [IDX_W-1:0] idx;
  } rsp_slot_t;

  // Increment a manager index, wrapping explicitly at n-1 so non-power-of-two counts stay legal.
  function automatic logic [IDX_W-1:0] idx_wrap_inc(input logic [IDX_W-1:0] idx, input int unsigned n);
    if (32'(idx) + 32'd1 >= n) return '0;
    return idx + IDX_W'(1);
  endfunction

endpackage

// File: rtl/tcb_arb_rr_pe.sv
// Rotating priority encoder: first asserted request scanning from ptr upward, modulo PN.
module tcb_arb_rr_pe #(
  parameter int unsigned PN = 2,
  parameter int unsigned IW = (PN > 1) ? $clog2(PN) : 1
) (
  input  logic [PN-1:0] req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] gnt,
  output logic          any
);

  // Scan PN positions starting at ptr; the first hit wins, ptr is reported when nothing requests.
  always_comb begin
    logic [IW-1:0] idx;
    gnt = ptr;
    any = 1'b0;
    idx = ptr;
    for (int unsigned i = 0; i < PN; i++) begin
      idx = IW'((32'(ptr) + i) % PN);
      if (!any && req[idx]) begin
        gnt = idx;
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tcb_arb_rr.sv
// Round-robin arbiter sharing one TCB subordinate between PN managers, with grant lock
// during subordinate stalls and delayed response routing back to the issuing manager.
module tcb_arb_rr
  import tcb_arb_rr_pkg::*;
#(
  parameter int unsigned AW  = TCB_AW,
  parameter int unsigned DW  = TCB_DW,
  parameter int unsigned BW  = DW / 8,
  parameter int unsigned PN  = 2,
  parameter int unsigned DLY = TCB_DLY,
  parameter int unsigned IW  = (PN > 1) ? $clog2(PN) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PN-1:0]    man_vld,
  input  logic [PN-1:0]    man_wen,
  input  logic [PN*AW-1:0] man_adr,
  input  logic [PN*BW-1:0] man_ben,
  input  logic [PN*DW-1:0] man_wdt,
  output logic [PN*DW-1:0] man_rdt,
  output logic [PN-1:0]    man_err,
  output logic [PN-1:0]    man_rdy,
  output logic             sub_vld,
  output logic             sub_wen,
  output logic [AW-1:0]    sub_adr,
  output logic [BW-1:0]    sub_ben,
  output logic [DW-1:0]    sub_wdt,
  input  logic [DW-1:0]    sub_rdt,
  input  logic             sub_err,
  input  logic             sub_rdy,
  output logic [IW-1:0]    gnt_idx
);

  logic [IW-1:0] ptr;
  logic          lck;
  logic [IW-1:0] lck_idx;
  logic [IW-1:0] pe_gnt;
  logic          pe_any;
  logic [IW-1:0] gnt;
  logic          hs;
  rsp_slot_t     rsp;

  tcb_arb_rr_pe #(
    .PN (PN),
    .IW (IW)
  ) u_pe (
    .req (man_vld),
    .ptr (ptr),
    .gnt (pe_gnt),
    .any (pe_any)
  );

  // A stalled grant is held so the subordinate never sees the request switch mid-transfer.
  assign gnt     = lck ? lck_idx : pe_gnt;
  assign gnt_idx = gnt;

  // Forward the granted manager's request onto the subordinate port.
  assign sub_vld = ~rst & pe_any & man_vld[gnt];
  assign sub_wen = man_wen[gnt];
  assign sub_adr = man_adr[32'(gnt)*AW +: AW];
  assign sub_ben = man_ben[32'(gnt)*BW +: BW];
  assign sub_wdt = man_wdt[32'(gnt)*DW +: DW];
  assign hs      = sub_vld & sub_rdy;

  // Only the granted manager sees ready, and only when the subordinate accepts.
  always_comb begin
    man_rdy = '0;
    if (hs) man_rdy[gnt] = 1'b1;
  end

  // Priority pointer advances past the winner on each transfer; lock tracks subordinate stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr     <= '0;
      lck     <= 1'b0;
      lck_idx <= '0;
    end else if (hs) begin
      ptr     <= IW'(idx_wrap_inc(IDX_W'(gnt), PN));
      lck     <= 1'b0;
    end else if (sub_vld) begin
      lck     <= 1'b1;
      lck_idx <= gnt;
    end
  end

  // Response pipe mirrors the subordinate latency so the reply finds its issuer.
  if (DLY == 0) begin : g_dly0
    assign rsp = {hs, IDX_W'(gnt)};
  end else begin : g_pipe
    rsp_slot_t pipe [DLY];

    // Shift issuer tags one stage per cycle; reset drops anything in flight.
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int unsigned i = 0; i < DLY; i++) pipe[i] <= '0;
      end else begin
        pipe[0] <= {hs, IDX_W'(gnt)};
        for (int unsigned i = 1; i < DLY; i++) pipe[i] <= pipe[i-1];
      end
    end

    assign rsp = pipe[DLY-1];
  end

  // Steer subordinate read data and error to the issuing manager; everyone else sees zero.
  always_comb begin
    man_rdt = '0;
    man_err = '0;
    if (!rst && rsp.vld) begin
      for (int unsigned k = 0; k < PN; k++) begin
        if (rsp.idx == IDX_W'(k)) begin
          man_rdt[k*DW +: DW] = sub_rdt;
          man_err[k]          = sub_err;
        end
      end
    end
  end

endmodule

// File: tb/tb_tcb_arb_rr.sv
// Self-checking bench for tcb_arb_rr: a PN=2/DLY=1 and a PN=3/DLY=2 instance, each with a
// subordinate model fed from a response scoreboard and a monitor comparing delivered responses.
module tb_tcb_arb_rr;

  typedef struct {
    int          idx;
    logic [31:0] rdt;
    logic        err;
    int          due;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc      = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  exp_t q2[$];
  exp_t q3[$];

  // PN=2, DLY=1 instance signals
  logic [1:0]  vld2, wen2, err2, rdy2;
  logic [63:0] adr2, wdt2, rdt2;
  logic [7:0]  ben2;
  logic        s_vld2, s_wen2, s_err2, s_rdy2;
  logic [31:0] s_adr2, s_wdt2, s_rdt2;
  logic [3:0]  s_ben2;
  logic [0:0]  gnt2;

  // PN=3, DLY=2 instance signals
  logic [2:0]  vld3, wen3, err3, rdy3;
  logic [95:0] adr3, wdt3, rdt3;
  logic [11:0] ben3;
  logic        s_vld3, s_wen3, s_err3, s_rdy3;
  logic [31:0] s_adr3, s_wdt3, s_rdt3;
  logic [3:0]  s_ben3;
  logic [1:0]  gnt3;

  tcb_arb_rr #(.AW(32), .DW(32), .PN(2), .DLY(1)) u_dut2 (
    .clk(clk), .rst(rst),
    .man_vld(vld2), .man_wen(wen2), .man_adr(adr2), .man_ben(ben2), .man_wdt(wdt2),
    .man_rdt(rdt2), .man_err(err2), .man_rdy(rdy2),
    .sub_vld(s_vld2), .sub_wen(s_wen2), .sub_adr(s_adr2), .sub_ben(s_ben2), .sub_wdt(s_wdt2),
    .sub_rdt(s_rdt2), .sub_err(s_err2), .sub_rdy(s_rdy2), .gnt_idx(gnt2)
  );

  tcb_arb_rr #(.AW(32), .DW(32), .PN(3), .DLY(2)) u_dut3 (
    .clk(clk), .rst(rst),
    .man_vld(vld3), .man_wen(wen3), .man_adr(adr3), .man_ben(ben3), .man_wdt(wdt3),
    .man_rdt(rdt3), .man_err(err3), .man_rdy(rdy3),
    .sub_vld(s_vld3), .sub_wen(s_wen3), .sub_adr(s_adr3), .sub_ben(s_ben3), .sub_wdt(s_wdt3),
    .sub_rdt(s_rdt3), .sub_err(s_err3), .sub_rdy(s_rdy3), .gnt_idx(gnt3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Subordinate models: return the scoreboard's data on the due cycle, noise otherwise.
  always @(posedge clk) begin
    #1;
    if (q2.size() > 0 && q2[0].due == cyc) begin
      s_rdt2 = q2[0].rdt;
      s_err2 = q2[0].err;
    end else begin
      s_rdt2 = $urandom;
      s_err2 = 1'($urandom_range(0, 1));
    end
    if (q3.size() > 0 && q3[0].due == cyc) begin
      s_rdt3 = q3[0].rdt;
      s_err3 = q3[0].err;
    end else begin
      s_rdt3 = $urandom;
      s_err3 = 1'($urandom_range(0, 1));
    end
  end

  // Response monitors: every cycle, compare routed responses with the scoreboard front.
  always @(negedge clk) begin
    logic [63:0] er2;
    logic [1:0]  ee2;
    logic [95:0] er3;
    logic [2:0]  ee3;
    er2 = '0; ee2 = '0; er3 = '0; ee3 = '0;
    if (q2.size() > 0 && q2[0].due == cyc) begin
      er2[q2[0].idx*32 +: 32] = q2[0].rdt;
      ee2[q2[0].idx]          = q2[0].err;
      void'(q2.pop_front());
    end
    if (q3.size() > 0 && q3[0].due == cyc) begin
      er3[q3[0].idx*32 +: 32] = q3[0].rdt;
      ee3[q3[0].idx]          = q3[0].err;
      void'(q3.pop_front());
    end
    n_checks++;
    if (rdt2 !== er2 || err2 !== ee2) begin
      n_errors++;
      $display("FAIL rsp2 cyc=%0d: rdt=%h err=%b, expected rdt=%h err=%b", cyc, rdt2, err2, er2, ee2);
    end
    n_checks++;
    if (rdt3 !== er3 || err3 !== ee3) begin
      n_errors++;
      $display("FAIL rsp3 cyc=%0d: rdt=%h err=%b, expected rdt=%h err=%b", cyc, rdt3, err3, er3, ee3);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push2(input int idx, input logic [31:0] rdt, input logic err);
    q2.push_back('{idx: idx, rdt: rdt, err: err, due: cyc + 1});
  endtask

  task automatic push3(input int idx, input logic [31:0] rdt, input logic err);
    q3.push_back('{idx: idx, rdt: rdt, err: err, due: cyc + 2});
  endtask

  task automatic test_reset();
    tick();
    vld2 = 2'b11; vld3 = 3'b111; s_rdy2 = 1'b1; s_rdy3 = 1'b1;
    #1;
    n_checks++;
    if (s_vld2 !== 1'b0 || rdy2 !== 2'b00 || s_vld3 !== 1'b0 || rdy3 !== 3'b000) begin
      n_errors++;
      $display("FAIL reset_quiet: sub_vld=%b/%b rdy=%b/%b, expected 0/0 00/000", s_vld2, s_vld3, rdy2, rdy3);
    end
    tick();
    rst = 1'b0; vld2 = '0; vld3 = '0;
    #1;
    n_checks++;
    if (gnt2 !== 1'd0 || gnt3 !== 2'd0 || s_vld2 !== 1'b0 || s_vld3 !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_idle: gnt=%0d/%0d sub_vld=%b/%b, expected 0/0 0/0", gnt2, gnt3, s_vld2, s_vld3);
    end
  endtask

  task automatic test_alternate();
    int          cnt0, cnt1, e;
    logic [1:0]  e_rdy;
    logic [31:0] e_adr;
    cnt0 = 0; cnt1 = 0;
    adr2 = {32'h0000_0200, 32'h0000_0100};
    wdt2 = {32'hBBBB_0001, 32'hAAAA_0000};
    wen2 = 2'b00; ben2 = 8'hFF; s_rdy2 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      vld2 = 2'b11;
      #1;
      e = i % 2;
      e_rdy = '0; e_rdy[e] = 1'b1;
      e_adr = (e == 1) ? 32'h0000_0200 : 32'h0000_0100;
      n_checks++;
      if (gnt2 !== 1'(e) || rdy2 !== e_rdy || s_adr2 !== e_adr) begin
        n_errors++;
        $display("FAIL alternate[%0d]: gnt=%0d rdy=%b adr=%h, expected gnt=%0d rdy=%b adr=%h",
                 i, gnt2, rdy2, s_adr2, e, e_rdy, e_adr);
      end
      if (rdy2[0] === 1'b1) cnt0++;
      if (rdy2[1] === 1'b1) cnt1++;
      push2(e, 32'hA000_0000 + 32'(i), 1'(i % 3 == 0));
    end
    tick();
    vld2 = 2'b00;
    n_checks++;
    if (cnt0 != 3 || cnt1 != 3) begin
      n_errors++;
      $display("FAIL alternate_count: m0=%0d m1=%0d, expected 3 and 3", cnt0, cnt1);
    end
  endtask

  task automatic test_single_read();
    tick();
    vld2 = 2'b01; wen2 = 2'b00; adr2[31:0] = 32'h0000_0010; s_rdy2 = 1'b1;
    #1;
    n_checks++;
    if (rdy2 !== 2'b01 || s_vld2 !== 1'b1 || s_wen2 !== 1'b0 || s_adr2 !== 32'h0000_0010) begin
      n_errors++;
      $display("FAIL single_read: rdy=%b vld=%b wen=%b adr=%h, expected 01 1 0 00000010", rdy2, s_vld2, s_wen2, s_adr2);
    end
    push2(0, 32'hDEAD_BEEF, 1'b0);
    tick();
    vld2 = 2'b00;
  endtask

  task automatic test_stall();
    adr2[63:32] = 32'h0000_0300;
    tick();
    vld2 = 2'b10; s_rdy2 = 1'b1;
    #1;
    n_checks++;
    if (rdy2 !== 2'b10) begin
      n_errors++;
      $display("FAIL stall_pre: rdy=%b, expected 10", rdy2);
    end
    push2(1, 32'h5555_0001, 1'b0);
    tick();
    vld2 = 2'b10; s_rdy2 = 1'b0;
    #1;
    n_checks++;
    if (gnt2 !== 1'd1 || rdy2 !== 2'b00 || s_vld2 !== 1'b1 || s_adr2 !== 32'h0000_0300) begin
      n_errors++;
      $display("FAIL stall_start: gnt=%0d rdy=%b vld=%b adr=%h, expected 1 00 1 00000300", gnt2, rdy2, s_vld2, s_adr2);
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      vld2 = 2'b11; s_rdy2 = 1'b0;
      #1;
      n_checks++;
      if (gnt2 !== 1'd1 || rdy2 !== 2'b00) begin
        n_errors++;
        $display("FAIL stall_hold[%0d]: gnt=%0d rdy=%b, expected 1 00", i, gnt2, rdy2);
      end
    end
    tick();
    vld2 = 2'b11; s_rdy2 = 1'b1;
    #1;
    n_checks++;
    if (gnt2 !== 1'd1 || rdy2 !== 2'b10) begin
      n_errors++;
      $display("FAIL stall_release: gnt=%0d rdy=%b, expected 1 10", gnt2, rdy2);
    end
    push2(1, 32'h5555_0002, 1'b1);
    tick();
    vld2 = 2'b01;
    #1;
    n_checks++;
    if (gnt2 !== 1'd0 || rdy2 !== 2'b01) begin
      n_errors++;
      $display("FAIL stall_next: gnt=%0d rdy=%b, expected 0 01", gnt2, rdy2);
    end
    push2(0, 32'h5555_0003, 1'b0);
    tick();
    vld2 = 2'b00;
  endtask

  task automatic test_write_err();
    tick();
    vld2 = 2'b10; wen2 = 2'b10; s_rdy2 = 1'b1;
    adr2[63:32] = 32'h0000_0040; wdt2[63:32] = 32'hCAFE_F00D; ben2[7:4] = 4'b0011;
    #1;
    n_checks++;
    if (rdy2 !== 2'b10 || s_wen2 !== 1'b1 || s_wdt2 !== 32'hCAFE_F00D || s_ben2 !== 4'b0011 || s_adr2 !== 32'h0000_0040) begin
      n_errors++;
      $display("FAIL write_req: rdy=%b wen=%b wdt=%h ben=%b adr=%h, expected 10 1 cafef00d 0011 00000040",
               rdy2, s_wen2, s_wdt2, s_ben2, s_adr2);
    end
    push2(1, 32'h0000_0000, 1'b1);
    tick();
    vld2 = 2'b00; wen2 = 2'b00;
  endtask

  task automatic test_pn3_wrap();
    adr3 = {32'h0000_2000, 32'h0000_1000, 32'h0000_0000};
    wen3 = 3'b000; ben3 = 12'hFFF; wdt3 = '0; s_rdy3 = 1'b1;
    tick();
    vld3 = 3'b010;
    #1;
    n_checks++;
    if (gnt3 !== 2'd1 || rdy3 !== 3'b010) begin
      n_errors++;
      $display("FAIL pn3_setup: gnt=%0d rdy=%b, expected 1 010", gnt3, rdy3);
    end
    push3(1, 32'h3333_3333, 1'b0);
    tick();
    vld3 = 3'b101;
    #1;
    n_checks++;
    if (gnt3 !== 2'd2 || rdy3 !== 3'b100 || s_adr3 !== 32'h0000_2000) begin
      n_errors++;
      $display("FAIL pn3_m2: gnt=%0d rdy=%b adr=%h, expected 2 100 00002000", gnt3, rdy3, s_adr3);
    end
    push3(2, 32'h1111_1111, 1'b0);
    tick();
    vld3 = 3'b011;
    #1;
    n_checks++;
    if (gnt3 !== 2'd0 || rdy3 !== 3'b001) begin
      n_errors++;
      $display("FAIL pn3_wrap: gnt=%0d rdy=%b, expected 0 001", gnt3, rdy3);
    end
    push3(0, 32'h2222_2222, 1'b0);
    tick();
    vld3 = 3'b010;
    #1;
    n_checks++;
    if (gnt3 !== 2'd1 || rdy3 !== 3'b010) begin
      n_errors++;
      $display("FAIL pn3_m1: gnt=%0d rdy=%b, expected 1 010", gnt3, rdy3);
    end
    push3(1, 32'h4444_4444, 1'b1);
    tick();
    vld3 = 3'b000;
    #1;
    n_checks++;
    if (gnt3 !== 2'd2 || s_vld3 !== 1'b0) begin
      n_errors++;
      $display("FAIL pn3_idle: gnt=%0d vld=%b, expected 2 0", gnt3, s_vld3);
    end
    repeat (4) tick();
  endtask

  task automatic test_reset_inflight();
    tick();
    vld3 = 3'b001; s_rdy3 = 1'b1;
    #1;
    n_checks++;
    if (rdy3 !== 3'b001) begin
      n_errors++;
      $display("FAIL inflight_hs: rdy=%b, expected 001", rdy3);
    end
    tick();
    vld3 = 3'b010; rst = 1'b1;
    #1;
    n_checks++;
    if (s_vld3 !== 1'b0 || rdy3 !== 3'b000) begin
      n_errors++;
      $display("FAIL inflight_rst: vld=%b rdy=%b, expected 0 000", s_vld3, rdy3);
    end
    tick();
    rst = 1'b0; vld3 = 3'b000;
    #1;
    n_checks++;
    if (gnt3 !== 2'd0) begin
      n_errors++;
      $display("FAIL inflight_ptr: gnt=%0d, expected 0", gnt3);
    end
    tick();
    vld3 = 3'b010;
    #1;
    n_checks++;
    if (gnt3 !== 2'd1 || rdy3 !== 3'b010) begin
      n_errors++;
      $display("FAIL inflight_next: gnt=%0d rdy=%b, expected 1 010", gnt3, rdy3);
    end
    push3(1, 32'h7777_7777, 1'b0);
    tick();
    vld3 = 3'b000;
    repeat (4) tick();
  endtask

  initial begin
    rst = 1'b1;
    vld2 = '0; wen2 = '0; adr2 = '0; ben2 = '0; wdt2 = '0; s_rdy2 = 1'b0;
    vld3 = '0; wen3 = '0; adr3 = '0; ben3 = '0; wdt3 = '0; s_rdy3 = 1'b0;
    s_rdt2 = '0; s_err2 = 1'b0; s_rdt3 = '0; s_err3 = 1'b0;

    test_reset();
    test_alternate();
    test_single_read();
    test_stall();
    test_write_err();
    test_pn3_wrap();
    test_reset_inflight();

    repeat (3) tick();
    n_checks++;
    if (q2.size() != 0 || q3.size() != 0) begin
      n_errors++;
      $display("FAIL drain: pending=%0d/%0d, expected 0/0", q2.size(), q3.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
